// File: rtl/fifo_rd_stream.sv
// Read-side adapter for spram_fifo. It issues FIFO reads against a credit
// budget, captures the returned words in a small prefetch ring, and presents
// them as a valid/ready stream at up to one beat per cycle.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = $clog2(BUF_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_ren,
  input  logic                  fifo_empty,
  input  logic                  fifo_rvalid,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  buf_count,
  output logic                  err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(BUF_DEPTH);
  localparam logic [CNT_WIDTH:0]   DEPTH_EXT = (CNT_WIDTH + 1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  inflight;
  logic [CNT_WIDTH:0]    credit;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  logic                  capture;
  logic                  retire;

  // Stream side: the head entry is visible whenever the ring holds a word.
  assign m_valid   = (count != '0);
  assign m_data    = m_valid ? buf_mem[head] : '0;
  assign buf_count = count;
  assign pop       = m_valid && m_ready;

  // Credit check counts the slot freed by this cycle's pop, so a draining
  // consumer keeps one read issued per cycle. One extra bit keeps the sum
  // from wrapping even if a stray word has overfilled the accounting.
  assign credit   = {1'b0, count} + {1'b0, inflight} - {{CNT_WIDTH{1'b0}}, pop};
  assign fifo_ren = !rst && !fifo_empty && (credit < DEPTH_EXT);
  assign accept   = fifo_ren && !fifo_empty;

  // A returning word with no free slot and no pop this cycle cannot be stored.
  assign drop    = fifo_rvalid && (count == FULL_CNT) && !pop;
  assign capture = fifo_rvalid && !drop;
  // Only credited words retire an in-flight slot; strays must not underflow it.
  assign retire  = fifo_rvalid && (inflight != '0);

  // Prefetch ring storage: written at the tail on each captured word.
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      buf_mem[tail] <= fifo_rdata;
    end
  end

  // Pointers, occupancy, outstanding-read count and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      head <= head + PTR_W'(pop);
      tail <= tail + PTR_W'(capture);
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({accept, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (fifo_rvalid && ((inflight == '0) || drop)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural one-cycle-latency
// FIFO model standing in for spram_fifo.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_ren;
  logic          fifo_empty;
  logic          fifo_rvalid;
  logic [DW-1:0] fifo_rdata;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] buf_count;
  logic          err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // FIFO model state
  logic [DW-1:0] fmem [0:63];
  int            wp = 0;
  int            rp = 0;
  logic          rv_m = 1'b0;
  logic [DW-1:0] rd_m = '0;
  logic          stray = 1'b0;

  assign fifo_empty  = (rp == wp);
  assign fifo_rvalid = rv_m | stray;
  assign fifo_rdata  = rd_m;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_ren   (fifo_ren),
    .fifo_empty (fifo_empty),
    .fifo_rvalid(fifo_rvalid),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_count  (buf_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  // FIFO model: read accepted on the edge, data returned the following cycle
  always @(posedge clk) begin
    if (rst) begin
      rv_m <= 1'b0;
      rp   <= wp;
    end else begin
      rv_m <= fifo_ren && !fifo_empty;
      if (fifo_ren && !fifo_empty) begin
        rd_m <= fmem[rp % 64];
        rp   <= rp + 1;
      end
    end
  end

  task automatic push(input logic [DW-1:0] v);
    fmem[wp % 64] = v;
    wp = wp + 1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (fifo_ren !== 1'b0) $display("FAIL reset_ren: got %b want 0", fifo_ren); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (buf_count !== 2'd0) $display("FAIL reset_count: got %0d want 0", buf_count); else pass_cnt++;
    total_cnt++; if (m_data !== 8'd0) $display("FAIL reset_data: got %0d want 0", m_data); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ev;
    step();
    for (int i = 0; i < 5; i++) push(8'(10 + i));
    #1;
    total_cnt++; if (fifo_ren !== 1'b1) $display("FAIL b2b_first_ren: got %b want 1", fifo_ren); else pass_cnt++;
    for (int k = 1; k <= 7; k++) begin
      step();
      ev = (k >= 2) && (k <= 6);
      total_cnt++; if (m_valid !== ev) $display("FAIL b2b_valid_c%0d: got %b want %b", k, m_valid, ev); else pass_cnt++;
      if (ev) begin
        total_cnt++; if (m_data !== 8'(8 + k)) $display("FAIL b2b_data_c%0d: got %0d want %0d", k, m_data, 8 + k); else pass_cnt++;
      end
    end
    total_cnt++; if (err !== 1'b0) $display("FAIL b2b_err: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_stall_release();
    int   pulses;
    logic held;
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(20 + i));
    #1;
    pulses = 0;
    held   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (fifo_ren) pulses++;
      if (m_valid && m_data !== 8'd20) held = 1'b0;
      step();
    end
    total_cnt++; if (pulses != BD) $display("FAIL stall_ren_pulses: got %0d want %0d", pulses, BD); else pass_cnt++;
    total_cnt++; if (buf_count !== 2'd2) $display("FAIL stall_count: got %0d want 2", buf_count); else pass_cnt++;
    total_cnt++; if (m_data !== 8'd20) $display("FAIL stall_data: got %0d want 20", m_data); else pass_cnt++;
    total_cnt++; if (held !== 1'b1) $display("FAIL stall_hold: got %b want 1", held); else pass_cnt++;
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (m_valid !== 1'b1 || m_data !== 8'(20 + i))
        $display("FAIL release_beat%0d: got valid=%b data=%0d want valid=1 data=%0d", i, m_valid, m_data, 20 + i);
      else pass_cnt++;
      step();
    end
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL release_drained: got %b want 0", m_valid); else pass_cnt++;
  endtask

  task automatic test_toggle_ready();
    logic [DW-1:0] expv [3];
    int   idx;
    logic over;
    expv[0] = 8'd65; expv[1] = 8'd22; expv[2] = 8'd13;
    step();
    push(8'd65); push(8'd22); push(8'd13);
    idx  = 0;
    over = 1'b0;
    for (int c = 0; c < 14; c++) begin
      m_ready = (c % 2 == 0);
      #1;
      if (m_valid && m_ready) begin
        total_cnt++;
        if (idx >= 3) $display("FAIL toggle_extra: got data=%0d want no further beat", m_data);
        else if (m_data !== expv[idx]) $display("FAIL toggle_beat%0d: got %0d want %0d", idx, m_data, expv[idx]);
        else pass_cnt++;
        idx++;
      end
      if (buf_count > 2'd2) over = 1'b1;
      step();
    end
    total_cnt++; if (idx != 3) $display("FAIL toggle_beats: got %0d want 3", idx); else pass_cnt++;
    total_cnt++; if (over !== 1'b0) $display("FAIL toggle_count_max: got over=%b want 0", over); else pass_cnt++;
    m_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    step();
    m_ready = 1'b0;
    push(8'd40); push(8'd41); push(8'd42);
    step();
    step();
    total_cnt++; if (buf_count !== 2'd1) $display("FAIL mid_setup_count: got %0d want 1", buf_count); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (fifo_ren !== 1'b0) $display("FAIL mid_ren_in_rst: got %b want 0", fifo_ren); else pass_cnt++;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (buf_count !== 2'd0) $display("FAIL mid_count: got %0d want 0", buf_count); else pass_cnt++;
    total_cnt++; if (fifo_ren !== 1'b0) $display("FAIL mid_ren_after: got %b want 0", fifo_ren); else pass_cnt++;
    rst = 1'b0;
    m_ready = 1'b1;
    push(8'd50);
    #1;
    total_cnt++; if (fifo_ren !== 1'b1) $display("FAIL mid_resume_ren: got %b want 1", fifo_ren); else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (m_valid !== 1'b1 || m_data !== 8'd50)
      $display("FAIL mid_resume_data: got valid=%b data=%0d want valid=1 data=50", m_valid, m_data);
    else pass_cnt++;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_resume_drain: got %b want 0", m_valid); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_stray_rvalid();
    step();
    m_ready = 1'b0;
    stray = 1'b1;
    #1;
    total_cnt++; if (fifo_ren !== 1'b0) $display("FAIL stray_ren: got %b want 0", fifo_ren); else pass_cnt++;
    step();
    stray = 1'b0;
    #1;
    total_cnt++; if (err !== 1'b1) $display("FAIL stray_err_set: got %b want 1", err); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (err !== 1'b1 || fifo_ren !== 1'b0)
        $display("FAIL stray_sticky%0d: got err=%b ren=%b want err=1 ren=0", i, err, fifo_ren);
      else pass_cnt++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total_cnt++; if (err !== 1'b0) $display("FAIL stray_err_clear: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_capture_pop();
    step();
    m_ready = 1'b0;
    push(8'd70); push(8'd71);
    step();
    step();
    total_cnt++; if (buf_count !== 2'd1) $display("FAIL cp_pre_count: got %0d want 1", buf_count); else pass_cnt++;
    total_cnt++; if (m_data !== 8'd70) $display("FAIL cp_pre_data: got %0d want 70", m_data); else pass_cnt++;
    m_ready = 1'b1;
    step();
    total_cnt++; if (buf_count !== 2'd1) $display("FAIL cp_count: got %0d want 1", buf_count); else pass_cnt++;
    total_cnt++; if (m_data !== 8'd71) $display("FAIL cp_data: got %0d want 71", m_data); else pass_cnt++;
    step();
    total_cnt++; if (buf_count !== 2'd0) $display("FAIL cp_drain: got %0d want 0", buf_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_release();
    test_toggle_ready();
    test_reset_mid();
    test_stray_rvalid();
    test_capture_pop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
